// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and default widths for the RAM port arbiter
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_B    = 2'd1,
    REQ_C    = 2'd2,
    REQ_D    = 2'd3
  } req_id_t;

  localparam int DEF_RAM_ADR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH    = 16;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rtl/ram_port_arbiter_rr_pick2.sv - two-input round-robin picker, tie goes to the side opposite rr_last
module rr_pick2 (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic upd_en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // rr_last = 1 means side b was granted last
  logic rr_last;

  assign gnt_a = req_a && (!req_b || rr_last);
  assign gnt_b = req_b && (!req_a || !rr_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (ce && upd_en && (gnt_a || gnt_b)) begin
      rr_last <= gnt_b;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one RAM port between boot loader, control unit and debug port
// Optional grant locking for C/D is enabled with macro ARB_LOCK_EN.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int RAM_ADR_WIDTH = DEF_RAM_ADR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     boot_mode,
  input  logic                     b_req,
  input  logic                     c_req,
  input  logic                     d_req,
  input  logic                     b_we,
  input  logic                     c_we,
  input  logic                     d_we,
  input  logic [RAM_ADR_WIDTH-1:0] b_adr,
  input  logic [RAM_ADR_WIDTH-1:0] c_adr,
  input  logic [RAM_ADR_WIDTH-1:0] d_adr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  input  logic [DATA_WIDTH-1:0]    c_wdata,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  input  logic                     c_lock,
  input  logic                     d_lock,
  output logic                     b_gnt,
  output logic                     c_gnt,
  output logic                     d_gnt,
  output logic                     b_rvalid,
  output logic                     c_rvalid,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [RAM_ADR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_rw,
  output logic                     ram_enable,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  logic    lock_c, lock_d;
  logic    c_elig, d_elig;
  req_id_t rd_owner, rd_next;

`ifdef ARB_LOCK_EN
  req_id_t lock_owner;

  assign lock_c = (lock_owner == REQ_C) && c_req && c_lock && !boot_mode;
  assign lock_d = (lock_owner == REQ_D) && d_req && d_lock;

  // A B grant leaves both C and D ungranted, which clears the lock here too
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_owner <= REQ_NONE;
    end else if (ce) begin
      if (c_gnt && c_lock)      lock_owner <= REQ_C;
      else if (d_gnt && d_lock) lock_owner <= REQ_D;
      else                      lock_owner <= REQ_NONE;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = c_lock ^ d_lock;
  assign lock_c = 1'b0;
  assign lock_d = 1'b0;
`endif

  assign b_gnt  = ce && b_req;
  assign c_elig = ce && !b_req && !boot_mode && c_req && !lock_d;
  assign d_elig = ce && !b_req && d_req && !lock_c;

  rr_pick2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .upd_en (!(lock_c || lock_d)),
    .req_a  (c_elig),
    .req_b  (d_elig),
    .gnt_a  (c_gnt),
    .gnt_b  (d_gnt)
  );

  assign ram_enable = b_gnt || c_gnt || d_gnt;
  assign rdata      = ram_dout;

  always_comb begin
    ram_adr = '0;
    ram_din = '0;
    ram_rw  = 1'b0;
    rd_next = REQ_NONE;
    if (b_gnt) begin
      ram_adr = b_adr;
      ram_din = b_wdata;
      ram_rw  = b_we;
      rd_next = b_we ? REQ_NONE : REQ_B;
    end else if (c_gnt) begin
      ram_adr = c_adr;
      ram_din = c_wdata;
      ram_rw  = c_we;
      rd_next = c_we ? REQ_NONE : REQ_C;
    end else if (d_gnt) begin
      ram_adr = d_adr;
      ram_din = d_wdata;
      ram_rw  = d_we;
      rd_next = d_we ? REQ_NONE : REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner <= REQ_NONE;
    end else if (ce) begin
      rd_owner <= rd_next;
    end
  end

  // Gated by rst_n so a read returning during reset never shows a strobe
  assign b_rvalid = rst_n && (rd_owner == REQ_B);
  assign c_rvalid = rst_n && (rd_owner == REQ_C);
  assign d_rvalid = rst_n && (rd_owner == REQ_D);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - table-driven bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, ce, boot_mode;
  logic        b_req, c_req, d_req, b_we, c_we, d_we, c_lock, d_lock;
  logic [5:0]  b_adr, c_adr, d_adr;
  logic [15:0] b_wdata, c_wdata, d_wdata;
  logic        b_gnt, c_gnt, d_gnt, b_rvalid, c_rvalid, d_rvalid;
  logic [15:0] rdata, ram_din, ram_dout;
  logic [5:0]  ram_adr;
  logic        ram_rw, ram_enable;

  logic [15:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .boot_mode(boot_mode),
    .b_req(b_req), .c_req(c_req), .d_req(d_req),
    .b_we(b_we), .c_we(c_we), .d_we(d_we),
    .b_adr(b_adr), .c_adr(c_adr), .d_adr(d_adr),
    .b_wdata(b_wdata), .c_wdata(c_wdata), .d_wdata(d_wdata),
    .c_lock(c_lock), .d_lock(d_lock),
    .b_gnt(b_gnt), .c_gnt(c_gnt), .d_gnt(d_gnt),
    .b_rvalid(b_rvalid), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .rdata(rdata), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_rw(ram_rw), .ram_enable(ram_enable), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_din;
      else        ram_dout     <= mem[ram_adr];
    end
  end

  typedef struct {
    logic        rs, ce, bm;
    logic [2:0]  req, we;
    logic [1:0]  lk;
    logic [5:0]  badr, cadr, dadr;
    logic [15:0] wd;
    logic [2:0]  egnt, erv;
    logic        een, erw;
    logic [5:0]  eadr;
    logic [15:0] edin;
    logic        chk;
    logic [15:0] erd;
  } vec_t;

  vec_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %h, want %h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rs; ce = v.ce; boot_mode = v.bm;
    {b_req, c_req, d_req} = v.req;
    {b_we, c_we, d_we}    = v.we;
    {c_lock, d_lock}      = v.lk;
    b_adr = v.badr; c_adr = v.cadr; d_adr = v.dadr;
    b_wdata = v.wd; c_wdata = v.wd; d_wdata = v.wd;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    ram_dout = 16'h0;

    // reset/tie order, boot priority, write then read, ce stall, reset mid-read, B read
    q.push_back('{1'b0,1'b1,1'b0,3'b111,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b100,3'b000,1'b1,1'b0,6'd1,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b000,1'b1,1'b0,6'd5,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b010,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b001,1'b1,1'b0,6'd5,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b010,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b1,3'b111,3'b100,2'b00,6'd3,6'd5,6'd9,16'hBEEF, 3'b100,3'b001,1'b1,1'b1,6'd3,16'hBEEF,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b1,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b000,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b001,1'b1,1'b0,6'd5,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b001,3'b000,2'b00,6'd1,6'd5,6'd3,16'h0000, 3'b001,3'b010,1'b1,1'b0,6'd3,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b001,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hBEEF});
    q.push_back('{1'b1,1'b1,1'b0,3'b010,3'b010,2'b00,6'd1,6'd7,6'd9,16'h1234, 3'b010,3'b000,1'b1,1'b1,6'd7,16'h1234,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b010,3'b000,2'b00,6'd1,6'd7,6'd9,16'h0000, 3'b010,3'b000,1'b1,1'b0,6'd7,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b010,1'b0,1'b0,6'd0,16'h0000,1'b1,16'h1234});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b000,1'b0,1'b0,6'd0,16'h0000,1'b1,16'h1234});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b000,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    for (int k = 0; k < 3; k++)
      q.push_back('{1'b1,1'b0,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b001,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hA009});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b001,1'b1,1'b0,6'd5,16'h0000,1'b1,16'hA009});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b010,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hA005});
    q.push_back('{1'b1,1'b1,1'b0,3'b001,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b000,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b0,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b000,1'b0,1'b0,6'd0,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b000,1'b1,1'b0,6'd5,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b010,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hA005});
    q.push_back('{1'b1,1'b1,1'b0,3'b100,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b100,3'b000,1'b1,1'b0,6'd1,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b100,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hA001});
`ifdef ARB_LOCK_EN
    // D holds lock for 4 grants, releases to C, then B preempts a fresh lock
    for (int k = 0; k < 4; k++)
      q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b01,6'd1,6'd5,6'd9,16'h0000, 3'b001,(k == 0) ? 3'b000 : 3'b001,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b001,1'b1,1'b0,6'd5,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b01,6'd1,6'd5,6'd9,16'h0000, 3'b001,3'b010,1'b1,1'b0,6'd9,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b111,3'b000,2'b01,6'd1,6'd5,6'd9,16'h0000, 3'b100,3'b001,1'b1,1'b0,6'd1,16'h0000,1'b0,16'h0000});
    q.push_back('{1'b1,1'b1,1'b0,3'b011,3'b000,2'b01,6'd1,6'd5,6'd9,16'h0000, 3'b010,3'b100,1'b1,1'b0,6'd5,16'h0000,1'b1,16'hA001});
    q.push_back('{1'b1,1'b1,1'b0,3'b000,3'b000,2'b00,6'd1,6'd5,6'd9,16'h0000, 3'b000,3'b010,1'b0,1'b0,6'd0,16'h0000,1'b1,16'hA005});
`endif

    drive('{1'b0,1'b1,1'b0,3'b000,3'b000,2'b00,6'd0,6'd0,6'd0,16'h0000, 3'b000,3'b000,1'b0,1'b0,6'd0,16'h0000,1'b0,16'h0000});
    @(posedge clk);

    for (int i = 0; i < q.size(); i++) begin
      cur = i;
      #1;
      drive(q[i]);
      #6;
      check("gnt",        {29'd0, b_gnt, c_gnt, d_gnt},          {29'd0, q[i].egnt});
      check("rvalid",     {29'd0, b_rvalid, c_rvalid, d_rvalid}, {29'd0, q[i].erv});
      check("ram_enable", {31'd0, ram_enable},                   {31'd0, q[i].een});
      check("ram_rw",     {31'd0, ram_rw},                       {31'd0, q[i].erw});
      check("ram_adr",    {26'd0, ram_adr},                      {26'd0, q[i].eadr});
      check("ram_din",    {16'd0, ram_din},                      {16'd0, q[i].edin});
      if (q[i].chk) check("rdata", {16'd0, rdata}, {16'd0, q[i].erd});
      @(posedge clk);
    end

    // free-running requests: grant must stay one-hot-or-zero with B on top
    for (int i = 0; i < 12; i++) begin
      cur = 1000 + i;
      #1;
      rst_n = 1'b1; ce = 1'b1; boot_mode = 1'b0;
      {b_req, c_req, d_req} = 3'($urandom_range(0, 7));
      {b_we, c_we, d_we} = 3'b000;
      {c_lock, d_lock} = 2'b00;
      #6;
      check("gnt_onehot", {31'd0, ($countones({b_gnt, c_gnt, d_gnt}) <= 1)}, 32'd1);
      check("enable_or",  {31'd0, ram_enable}, {31'd0, (b_req | c_req | d_req)});
      check("b_priority", {31'd0, b_gnt}, {31'd0, b_req});
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit program/data RAM between three requesters:
  - boot loader (B)
  - control unit (C)
  - debug/scan port (D)
- Replaces the plain boot-select mux in front of the RAM.
- Grants at most one access per cycle, drives the RAM port, and routes the read-valid strobe back to the owner one cycle later.

Parameters:
- RAM_ADR_WIDTH, 6, RAM address width.
- DATA_WIDTH, 16, RAM word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ce  in  1  clock enable; 0 freezes all state
- boot_mode  in  1  1 = boot loader phase; C requests masked
- b_req, c_req, d_req  in  1 each  access request
- b_we, c_we, d_we  in  1 each  1 = write, 0 = read
- b_adr, c_adr, d_adr  in  RAM_ADR_WIDTH each  address
- b_wdata, c_wdata, d_wdata  in  DATA_WIDTH each  write data
- c_lock, d_lock  in  1 each  hold grant (used only with ARB_LOCK_EN)
- b_gnt, c_gnt, d_gnt  out  1 each  combinational grant, same cycle as req
- b_rvalid, c_rvalid, d_rvalid  out  1 each  read data valid for owner
- rdata  out  DATA_WIDTH  read data, passthrough of ram_dout
- ram_adr  out  RAM_ADR_WIDTH  to RAM
- ram_din  out  DATA_WIDTH  to RAM
- ram_rw  out  1  1 = write
- ram_enable  out  1  RAM access strobe
- ram_dout  in  DATA_WIDTH  RAM output, valid one cycle after a read

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - rr_last := D, so C wins the first C/D tie.
  - All rvalid outputs := 0; rd_owner := none.
  - Lock owner := none.
- Arbitration (combinational, ce = 1):
  - If b_req: B wins. B has fixed top priority in either mode.
  - Else, if boot_mode = 1: only D is eligible; c_req is ignored.
  - Else: C and D round-robin. On a tie, the requester opposite rr_last wins.
  - A lone requester wins immediately.
- Exactly zero or one gnt is high in any cycle.
- ce = 0:
  - All gnt = 0 and ram_enable = 0.
  - rr_last, lock owner and the rvalid registers hold their values. The RAM output also holds, so they stay consistent.
- RAM drive:
  - ram_enable = OR of the gnt signals.
  - ram_rw, ram_adr and ram_din are muxed from the winner.
  - When nothing is granted, ram_rw = 0 and ram_adr/ram_din = 0.
- rr_last updates at the clk edge only when C or D is granted. B grants leave it unchanged.
- Read return:
  - A granted read in cycle N sets the owner's rvalid in cycle N+1, for exactly one cycle (ce = 1 throughout).
  - rdata = ram_dout.
  - Granted writes produce no rvalid.
  - Back-to-back reads by different owners each get their own single rvalid pulse, in order.
- Latency: grant 0 cycles, read data 1 cycle. Throughput is one access per cycle.
- boot_mode 1→0 mid-stream: rr_last is preserved and C becomes eligible the same cycle.
- Reset mid-read: the pending rvalid is dropped.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - When C or D is granted with its lock = 1, that requester becomes lock owner.
  - While the owner holds req & lock, the other of C/D is never granted, for example during read-modify-write.
  - The lock is released on the first cycle the owner has req = 0 or lock = 0.
  - B preempts any lock, and the lock is cleared when B is granted.
  - rr_last is not updated while the lock is held.
- Without the macro: c_lock and d_lock are ignored and there is no lock state.

Decomposition:
- Shared package holds:
  - requester id enum: REQ_NONE, REQ_B, REQ_C, REQ_D (2 bits)
  - RAM_ADR_WIDTH and DATA_WIDTH defaults
- One natural sub-module, rr_pick2: two-input round-robin picker with rr_last state and update enable.
- Port muxing and the rvalid pipeline stay in the top block.

Test Plan:
- Reset with all req high, then rst_n = 1, boot_mode = 0, b_req = 0, c_req = d_req = 1 (reads, adr 5 and 9):
  - c_gnt, d_gnt, c_gnt, … alternate every cycle.
  - ram_adr = 5, 9, 5, …
  - Matching rvalid arrives one cycle after each grant.
- boot_mode = 1, b_req = 1 write (adr 3, data 0xBEEF), c_req = 1 and d_req = 1 the same cycle:
  - b_gnt = 1, ram_rw = 1, ram_din = 0xBEEF; no other gnt.
  - Next cycle, B drops: d_gnt = 1 and c_gnt stays 0.
- C writes 0x1234 to adr 7, then C reads adr 7:
  - c_rvalid = 1 exactly one cycle after the read grant, rdata = 0x1234.
  - No rvalid follows the write.
- ce = 0 for 3 cycles with a read rvalid pending and c_req = 1:
  - No gnt and ram_enable = 0; rvalid/rdata hold.
  - When ce returns to 1, round-robin order resumes from the pre-stall rr_last.
- rst_n = 0 the cycle after a granted D read: d_rvalid never asserts, and the next C/D tie grants C.
- With ARB_LOCK_EN, d_req = d_lock = 1 for 4 cycles with c_req = 1:
  - d_gnt held for 4 cycles, c_gnt = 0.
  - On the cycle D drops lock, c_gnt = 1.
  - b_req mid-lock: b_gnt = 1 and the lock clears.
